// File: rtl/dcf77_pulse_decoder.sv
// dcf77_pulse_decoder
//   Decodes the 1 ms-tick DCF77 baseband signal. Each low pulse is measured
//   and classified (short = 0, long = 1). A fall-to-fall gap of at least
//   T_MINUTE_GAP marks the start of a minute. The 59 second bits of a minute
//   are assembled into a frame for the downstream time/date decoder.
//
// Ports
//   clk_in          tick clock, 1 tick = 1 ms
//   rst_in          synchronous, active-high reset
//   sgn_in          DCF77 baseband, idle high, low = second pulse (asynchronous)
//   bit_valid_out   one-cycle strobe: a bit was decoded
//   bit_out         decoded bit value, valid with bit_valid_out
//   bit_idx_out     index (0..58) of the decoded bit, valid with bit_valid_out
//   frame_valid_out one-cycle strobe: complete, error-free frame on frame_out
//   frame_out       frame, bit n = second n; held until the next frame_valid_out
//   sync_out        level: minute marker acquired
//   err_out         sticky error flag, cleared at the next minute marker
//
// Build option
//   DCF77_PARITY_CHECK_EN: when defined, a frame is only delivered if bit 0 = 0,
//   bit 20 = 1 and the three even-parity groups (21..28, 29..35, 36..58) hold.
//   A content failure raises err_out for one cycle before the marker handling
//   clears it.

module dcf77_pulse_decoder #(
  parameter int T_MIN_PULSE  = 50,
  parameter int T_BIT_THRESH = 150,
  parameter int T_MAX_PULSE  = 250,
  parameter int T_MINUTE_GAP = 1500,
  parameter int T_LOSS       = 3000,
  parameter int CNT_W        = 12
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        sgn_in,
  output logic        bit_valid_out,
  output logic        bit_out,
  output logic [5:0]  bit_idx_out,
  output logic        frame_valid_out,
  output logic [58:0] frame_out,
  output logic        sync_out,
  output logic        err_out
);

  typedef enum logic [0:0] {IDLE = 1'b0, SYNC = 1'b1} state_t;

  localparam logic [CNT_W-1:0] MIN_W  = CNT_W'(T_MIN_PULSE);
  localparam logic [CNT_W-1:0] THR_W  = CNT_W'(T_BIT_THRESH);
  localparam logic [CNT_W-1:0] MAX_W  = CNT_W'(T_MAX_PULSE);
  localparam logic [CNT_W-1:0] GAP_W  = CNT_W'(T_MINUTE_GAP);
  localparam logic [CNT_W-1:0] LOSS_W = CNT_W'(T_LOSS);
  localparam logic [CNT_W-1:0] SAT_W  = {CNT_W{1'b1}};
  localparam logic [5:0]       LAST_IDX = 6'd59;

  logic             s1;
  logic             s2;
  logic             s3;
  logic             fall;
  logic             rise;
  logic [CNT_W-1:0] width;
  logic [CNT_W-1:0] gap;
  state_t           state;
  logic [5:0]       idx;
  logic [58:0]      frame_shift;
  logic             marker_pend;
  logic             content_ok;

`ifdef DCF77_PARITY_CHECK_EN
  // Frame content rule: start bit 0, time-start bit 1, three even-parity groups.
  function automatic logic frame_content_ok(input logic [58:0] f);
    logic ok;
    ok = (f[0] == 1'b0) && (f[20] == 1'b1);
    ok = ok && ((^f[28:21]) == 1'b0);
    ok = ok && ((^f[35:29]) == 1'b0);
    ok = ok && ((^f[58:36]) == 1'b0);
    return ok;
  endfunction
`endif

  // Two-stage synchronizer plus previous-value stage; idle level is high.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
      s3 <= 1'b1;
    end else begin
      s1 <= sgn_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  // Edge detect on the synchronized signal.
  always_comb begin
    fall = s3 & ~s2;
    rise = ~s3 & s2;
  end

  // Low-width counter: holds the pulse width in ticks on the rise cycle.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      width <= {CNT_W{1'b0}};
    end else if (fall) begin
      width <= {{(CNT_W-1){1'b0}}, 1'b1};
    end else if (!s2 && (width != SAT_W)) begin
      width <= width + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      width <= width;
    end
  end

  // Fall-to-fall gap counter; T_LOSS means no usable previous fall.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      gap <= LOSS_W;
    end else if (fall) begin
      gap <= {{(CNT_W-1){1'b0}}, 1'b1};
    end else if (gap < LOSS_W) begin
      gap <= gap + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      gap <= gap;
    end
  end

  // Content check of the assembled frame (always passes without the option).
  always_comb begin
`ifdef DCF77_PARITY_CHECK_EN
    content_ok = frame_content_ok(frame_shift);
`else
    content_ok = 1'b1;
`endif
  end

  // Decoder state machine with all outputs registered.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state           <= IDLE;
      idx             <= 6'd0;
      frame_shift     <= 59'd0;
      marker_pend     <= 1'b0;
      bit_valid_out   <= 1'b0;
      bit_out         <= 1'b0;
      bit_idx_out     <= 6'd0;
      frame_valid_out <= 1'b0;
      frame_out       <= 59'd0;
      sync_out        <= 1'b0;
      err_out         <= 1'b0;
    end else begin
      bit_valid_out   <= 1'b0;
      frame_valid_out <= 1'b0;
      if (marker_pend) begin
        // Second half of a rejected marker: err_out was shown for one cycle.
        marker_pend <= 1'b0;
        idx         <= 6'd0;
        err_out     <= 1'b0;
        frame_shift <= 59'd0;
      end else begin
        case (state)
          IDLE: begin
            if (fall && (gap >= GAP_W) && (gap < LOSS_W)) begin
              state       <= SYNC;
              sync_out    <= 1'b1;
              idx         <= 6'd0;
              err_out     <= 1'b0;
              frame_shift <= 59'd0;
            end else begin
              state <= IDLE;
            end
          end
          SYNC: begin
            if (rise) begin
              if ((width < MIN_W) || (width > MAX_W)) begin
                err_out <= 1'b1;
              end else if (idx == LAST_IDX) begin
                err_out <= 1'b1;
              end else begin
                frame_shift[idx] <= (width >= THR_W);
                bit_valid_out    <= 1'b1;
                bit_out          <= (width >= THR_W);
                bit_idx_out      <= idx;
                idx              <= idx + 6'd1;
              end
            end else if (fall) begin
              if (gap >= GAP_W) begin
                if ((idx == LAST_IDX) && !err_out && !content_ok) begin
                  err_out     <= 1'b1;
                  marker_pend <= 1'b1;
                end else begin
                  if ((idx == LAST_IDX) && !err_out) begin
                    frame_out       <= frame_shift;
                    frame_valid_out <= 1'b1;
                  end
                  idx         <= 6'd0;
                  err_out     <= 1'b0;
                  frame_shift <= 59'd0;
                end
              end
            end else if (gap == LOSS_W) begin
              // Input stuck: drop sync; error stays until re-sync in IDLE.
              state       <= IDLE;
              sync_out    <= 1'b0;
              err_out     <= 1'b1;
              idx         <= 6'd0;
              frame_shift <= 59'd0;
            end
          end
          default: begin
            state    <= IDLE;
            sync_out <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dcf77_pulse_decoder.sv
module tb_dcf77_pulse_decoder;

  // Timing scaled down by 10 to keep the run short.
  localparam int TB_MIN  = 5;
  localparam int TB_THR  = 15;
  localparam int TB_MAX  = 25;
  localparam int TB_MGAP = 150;
  localparam int TB_LOSS = 300;
  localparam int TB_W0   = 10;
  localparam int TB_W1   = 20;
  localparam int TB_PER  = 100;
  localparam int TB_GAP  = 200;

  logic        clk = 1'b0;
  logic        rst_in;
  logic        sgn_in;
  logic        bit_valid_out;
  logic        bit_out;
  logic [5:0]  bit_idx_out;
  logic        frame_valid_out;
  logic [58:0] frame_out;
  logic        sync_out;
  logic        err_out;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int err_cycles = 0;
  int err_p0 = 0;
  int sync_fall_cyc = 0;
  int sync_up_cyc = -1;
  logic sync_prev = 1'b0;
  int w_arr [60];
  logic [6:0]  bq [$];
  logic [58:0] fq [$];

  dcf77_pulse_decoder #(
    .T_MIN_PULSE (TB_MIN),
    .T_BIT_THRESH(TB_THR),
    .T_MAX_PULSE (TB_MAX),
    .T_MINUTE_GAP(TB_MGAP),
    .T_LOSS      (TB_LOSS),
    .CNT_W       (12)
  ) dut (
    .clk_in         (clk),
    .rst_in         (rst_in),
    .sgn_in         (sgn_in),
    .bit_valid_out  (bit_valid_out),
    .bit_out        (bit_out),
    .bit_idx_out    (bit_idx_out),
    .frame_valid_out(frame_valid_out),
    .frame_out      (frame_out),
    .sync_out       (sync_out),
    .err_out        (err_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Output monitor: pops scoreboard entries when the DUT strobes.
  always @(negedge clk) begin
    logic [6:0]  eb;
    logic [58:0] ef;
    if (bit_valid_out) begin
      check("bit_expected", 64'(bq.size() != 0), 64'(1));
      if (bq.size() != 0) begin
        eb = bq.pop_front();
        check("bit_idx", 64'(bit_idx_out), 64'(eb[6:1]));
        check("bit_val", 64'(bit_out), 64'(eb[0]));
      end
    end
    if (frame_valid_out) begin
      check("frame_expected", 64'(fq.size() != 0), 64'(1));
      if (fq.size() != 0) begin
        ef = fq.pop_front();
        check("frame_out", 64'(frame_out), 64'(ef));
        check("frame_err", 64'(err_out), 64'(0));
      end
    end
    if (err_out) err_cycles++;
    if (sync_out && !sync_prev && (sync_up_cyc < 0)) sync_up_cyc = cyc;
    sync_prev = sync_out;
  end

  task automatic load_bits(input logic [58:0] b);
    for (int i = 0; i < 60; i++) begin
      if (i < 59) w_arr[i] = b[i] ? TB_W1 : TB_W0;
      else        w_arr[i] = TB_W0;
    end
  endtask

  // Sends npulse pulses from w_arr; the last is followed by a minute gap.
  task automatic send_frame(input int npulse);
    int          idx_e;
    bit          errs;
    bit          ok;
    logic [58:0] fr;
    int          w;
    idx_e = 0;
    errs  = 1'b0;
    fr    = 59'd0;
    for (int i = 0; i < npulse; i++) begin
      w = w_arr[i];
      if ((w < TB_MIN) || (w > TB_MAX) || (idx_e == 59)) begin
        errs = 1'b1;
      end else begin
        bq.push_back({6'(idx_e), 1'(w >= TB_THR)});
        fr[idx_e] = (w >= TB_THR);
        idx_e++;
      end
      sgn_in = 1'b0;
      repeat (w) @(negedge clk);
      sgn_in = 1'b1;
      repeat (((i == npulse - 1) ? TB_GAP : TB_PER) - w) @(negedge clk);
      check("err_level", 64'(err_out), 64'(errs));
      if (i == 0) err_p0 = err_cycles;
    end
`ifdef DCF77_PARITY_CHECK_EN
    ok = !fr[0] && fr[20] && !(^fr[28:21]) && !(^fr[35:29]) && !(^fr[58:36]);
`else
    ok = 1'b1;
`endif
    if ((idx_e == 59) && !errs && ok) fq.push_back(fr);
  endtask

  initial begin
    rst_in = 1'b1;
    sgn_in = 1'b1;
    repeat (3) @(negedge clk);
    rst_in = 1'b0;
    check("rst_bit_valid", 64'(bit_valid_out), 64'(0));
    check("rst_bit", 64'(bit_out), 64'(0));
    check("rst_bit_idx", 64'(bit_idx_out), 64'(0));
    check("rst_frame_valid", 64'(frame_valid_out), 64'(0));
    check("rst_frame", 64'(frame_out), 64'(0));
    check("rst_sync", 64'(sync_out), 64'(0));
    check("rst_err", 64'(err_out), 64'(0));

    // Idle line: nothing happens.
    repeat (400) @(negedge clk);
    check("idle_sync", 64'(sync_out), 64'(0));
    check("idle_err", 64'(err_out), 64'(0));

    // Arming fall in IDLE, then the sync fall starts frame A.
    sgn_in = 1'b0;
    repeat (TB_W0) @(negedge clk);
    sgn_in = 1'b1;
    repeat (TB_GAP - TB_W0) @(negedge clk);
    check("arm_sync", 64'(sync_out), 64'(0));

    // Frame A: only bit 20 set.
    load_bits(59'd1 << 20);
    sync_fall_cyc = cyc;
    send_frame(59);
    check("sync_latency", 64'(sync_up_cyc - sync_fall_cyc), 64'(3));

    // Frame with out-of-range widths: idx 5 too short, idx 30 too long.
    load_bits(59'd1 << 20);
    w_arr[5]  = TB_MIN - 1;
    w_arr[30] = TB_MAX + 1;
    send_frame(59);

    // Boundary widths that still decode.
    load_bits((59'd1 << 20) | (59'd1 << 3) | (59'd1 << 7));
    w_arr[3] = TB_THR;
    w_arr[4] = TB_THR - 1;
    w_arr[6] = TB_MIN;
    w_arr[7] = TB_MAX;
    send_frame(59);
    check("err_after_bad_frame", 64'(err_out), 64'(0));

    // Bits 20 and 21: content check decides delivery.
    load_bits((59'd1 << 20) | (59'd1 << 21));
    send_frame(59);

    // Frame with a 60th pulse; its marker is the parity frame's verdict.
    load_bits(59'd1 << 20);
    err_cycles = 0;
    send_frame(60);
`ifdef DCF77_PARITY_CHECK_EN
    check("parity_err_pulse", 64'(err_p0), 64'(1));
`else
    check("parity_err_pulse", 64'(err_p0), 64'(0));
`endif

    // Marker after the extra-pulse frame, then the line sticks high.
    bq.push_back(7'b0000000);
    sgn_in = 1'b0;
    repeat (TB_W0) @(negedge clk);
    sgn_in = 1'b1;
    repeat (TB_LOSS - 10 - TB_W0) @(negedge clk);
    check("pre_loss_sync", 64'(sync_out), 64'(1));
    check("pre_loss_err", 64'(err_out), 64'(0));
    repeat (30) @(negedge clk);
    check("loss_sync", 64'(sync_out), 64'(0));
    check("loss_err", 64'(err_out), 64'(1));

    // Re-arm in IDLE; error persists until the marker.
    sgn_in = 1'b0;
    repeat (TB_W0) @(negedge clk);
    sgn_in = 1'b1;
    repeat (TB_GAP - TB_W0) @(negedge clk);
    check("rearm_sync", 64'(sync_out), 64'(0));
    check("rearm_err", 64'(err_out), 64'(1));

    // Re-sync fall; its pulse is bit 0.
    bq.push_back(7'b0000000);
    sgn_in = 1'b0;
    repeat (TB_W0) @(negedge clk);
    sgn_in = 1'b1;
    repeat (TB_PER - TB_W0) @(negedge clk);
    check("resync_sync", 64'(sync_out), 64'(1));
    check("resync_err", 64'(err_out), 64'(0));

    // Bit 1, then reset in the middle of bit 2.
    bq.push_back({6'd1, 1'b1});
    sgn_in = 1'b0;
    repeat (TB_W1) @(negedge clk);
    sgn_in = 1'b1;
    repeat (TB_PER - TB_W1) @(negedge clk);
    sgn_in = 1'b0;
    repeat (5) @(negedge clk);
    rst_in = 1'b1;
    @(negedge clk);
    check("midrst_sync", 64'(sync_out), 64'(0));
    check("midrst_err", 64'(err_out), 64'(0));
    check("midrst_frame", 64'(frame_out), 64'(0));
    check("midrst_bit_idx", 64'(bit_idx_out), 64'(0));
    rst_in = 1'b0;
    repeat (10) @(negedge clk);
    sgn_in = 1'b1;
    repeat (50) @(negedge clk);
    check("midrst_sync_after", 64'(sync_out), 64'(0));

    check("bit_queue_empty", 64'(bq.size()), 64'(0));
    check("frame_queue_empty", 64'(fq.size()), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
